// File: rtl/jk_pkg.sv
// Shared encodings for the JK bank arbiter: cell commands, FSM states
// and the next-state rule every cell follows.
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        RESP  = 2'd2
    } state_t;

    function automatic logic jk_next(
        input logic       q,
        input logic [1:0] op
    );
        unique case (op)
            JK_HOLD:   return q;
            JK_RESET:  return 1'b0;
            JK_SET:    return 1'b1;
            JK_TOGGLE: return ~q;
            default:   return q;
        endcase
    endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Command/response bundle between requesters and the JK bank arbiter.
interface jk_bank_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 3
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [2*NUM_REQ-1:0]     req_op;
    logic [IDX_W*NUM_REQ-1:0] req_idx;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic [NUM_REQ-1:0]       rsp_gnt;
    logic                     rsp_q;
    logic                     rsp_err;

    modport master (
        output req_valid, req_op, req_idx,
        input  req_ready, rsp_valid, rsp_gnt, rsp_q, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_idx,
        output req_ready, rsp_valid, rsp_gnt, rsp_q, rsp_err
    );
endinterface

// File: rtl/jk_ff_cell.sv
// One clocked JK storage cell with enable and async clear.
module jk_ff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    input  logic en,
    output logic q
);
    import jk_pkg::*;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (en) begin
            q <= jk_next(q, {j, k});
        end
    end
endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a bank of JK cells among requesters;
// one command at a time, IDLE -> APPLY -> RESP.
module jk_bank_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_BITS = 8,
    parameter int IDX_W    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    jk_bank_arbiter_if.slave    bus,
    output logic [NUM_BITS-1:0] q_bus,
    output logic                busy
);
    import jk_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t              state;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    gnt_q;
    logic [PTR_W-1:0]    pick;
    logic [PTR_W-1:0]    cand;
    logic                pick_hit;
    logic [1:0]          pick_op;
    logic [1:0]          op_q;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    idx_q;
    logic                idx_bad;
    logic                cur_q;
    logic [NUM_BITS-1:0] cell_en;
    logic                rsp_valid_q;
    logic [NUM_REQ-1:0]  rsp_gnt_q;
    logic                rsp_q_q;
    logic                rsp_err_q;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        pick_hit = 1'b0;
        pick     = '0;
        cand     = '0;
        pick_op  = '0;
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!pick_hit && cand == PTR_W'(r) && bus.req_valid[r]) begin
                    pick_hit = 1'b1;
                    pick     = cand;
                    pick_op  = bus.req_op[2*r +: 2];
                    pick_idx = bus.req_idx[IDX_W*r +: IDX_W];
                end
            end
        end
    end

    assign bus.req_ready = (rst_n && state == IDLE && pick_hit)
                         ? (NUM_REQ'(1) << pick) : '0;

    assign idx_bad = (32'(idx_q) >= 32'(NUM_BITS));
    assign cur_q   = q_bus[idx_q];
    assign busy    = (state != IDLE);

    always_comb begin
        cell_en = '0;
        for (int b = 0; b < NUM_BITS; b++) begin
            cell_en[b] = (state == APPLY) && !idx_bad
                       && (idx_q == IDX_W'(b));
        end
    end

    for (genvar b = 0; b < NUM_BITS; b++) begin : g_cell
        jk_ff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (op_q[1]),
            .k     (op_q[0]),
            .en    (cell_en[b]),
            .q     (q_bus[b])
        );
    end

    // Response is registered at the same edge the cell updates,
    // so it carries the post-command value computed here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt_q       <= '0;
            op_q        <= '0;
            idx_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_gnt_q   <= '0;
            rsp_q_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_gnt_q   <= '0;
            rsp_q_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_hit) begin
                        op_q  <= pick_op;
                        idx_q <= pick_idx;
                        gnt_q <= pick;
                        ptr   <= (pick == PTR_W'(NUM_REQ - 1))
                               ? '0 : pick + 1'b1;
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    rsp_valid_q <= 1'b1;
                    rsp_gnt_q   <= NUM_REQ'(1) << gnt_q;
                    rsp_q_q     <= idx_bad ? 1'b0 : jk_next(cur_q, op_q);
                    rsp_err_q   <= idx_bad;
                    state       <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_gnt   = rsp_gnt_q;
    assign bus.rsp_q     = rsp_q_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
